// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: active-low segment codes,
// decimal-point placement and the digit count.
package seg_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // Positions whose decimal point is lit: separators after h1, m1 and s1.
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 8'b0101_0100;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low 7-segment decoder; non-decimal codes show blank.
module bcd_to_seg
  import seg_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // Pure lookup; anything above 9 is blanked rather than shown as a hex glyph.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed driver for a common-anode 7-segment display.
// Scans positions 0..7, inserts a dark guard cycle at the start of each slot,
// blinks the edited digit in edit mode and flashes everything when done.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] time_i,
  input  logic [2:0]  curr_digit,
  input  logic        edit,
  input  logic        done,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BC_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [2:0]            idx_reg, idx_next;
  logic [BC_W-1:0]       bc_reg, bc_next;
  logic                  ph_reg, ph_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic [6:0]            seg_reg, seg_next;
  logic                  dp_reg, dp_next;

  // Displayed nibble per position; ms1 (time_i[3:0]) is never shown.
  bcd_t digit_nib [NUM_DIGITS];
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign digit_nib[gi] = time_i[4*gi+4 +: 4];
    end
  endgenerate

  bcd_t       digit_sel;
  logic [6:0] dec_seg;
  logic [2:0] edit_pos;
  logic       edit_hit;
  logic       blank_now;

  assign digit_sel = digit_nib[idx_reg];

  bcd_to_seg u_dec (
    .bcd (digit_sel),
    .seg (dec_seg)
  );

  // Cursor 0..5 maps to positions 7..2; cursor 6/7 points at no digit.
  assign edit_pos  = 3'd7 - curr_digit;
  assign edit_hit  = edit && (curr_digit <= 3'd5) && (idx_reg == edit_pos);
  // Done flashes everything and therefore overrides the edit blink.
  assign blank_now = !ph_reg && (done || edit_hit);

  // Slot counter, position index and blink phase advance.
  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    bc_next  = bc_reg + BC_W'(1);
    ph_next  = ph_reg;
    if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      idx_next = idx_reg + 3'd1;
    end
    if (bc_reg == BC_LAST) begin
      bc_next = '0;
      ph_next = !ph_reg;
    end
  end

  // Output pattern for the next cycle, with a dark guard at each slot start.
  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (cnt_reg != '0) begin
      an_next = ~(NUM_DIGITS'(1) << idx_reg);
      if (!blank_now) begin
        seg_next = dec_seg;
        dp_next  = !DP_MASK[idx_reg];
      end
    end
  end

  // State and output registers; reset restarts scanning from a guard cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      bc_reg  <= '0;
      ph_reg  <= 1'b1;
      an_reg  <= '1;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
      bc_reg  <= bc_next;
      ph_reg  <= ph_next;
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV = 4, BLINK_HALF = 64.
module tb_seg_scan_display;

  localparam int SCAN_DIV   = 4;
  localparam int BLINK_HALF = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] time_i;
  logic [2:0]  curr_digit;
  logic        edit;
  logic        done;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;   // rising edges since the last reset release

  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  seg_scan_display #(
    .SCAN_DIV   (SCAN_DIV),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_i     (time_i),
    .curr_digit (curr_digit),
    .edit       (edit),
    .done       (done),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected outputs after edge kk, from the state reached after kk-1 edges.
  task automatic model(input int kk);
    int  c;
    int  i;
    bit  ph;
    bit  blank;
    logic [3:0] nib;
    c   = (kk - 1) % SCAN_DIV;
    i   = ((kk - 1) / SCAN_DIV) % 8;
    ph  = (((kk - 1) / BLINK_HALF) % 2) == 0;
    nib = time_i[4*i+4 +: 4];
    if (c == 0) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(8'h01 << i);
      blank = !ph && (done || (edit && curr_digit <= 3'd5 && i == 7 - int'(curr_digit)));
      e_seg = blank ? 7'h7F : seg_code(nib);
      e_dp  = blank ? 1'b1 : !(i == 2 || i == 4 || i == 6);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; time_i = 36'h123456789; curr_digit = 3'd0; edit = 1'b0; done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      n_checks++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL reset cyc=%0d an=%h seg=%h dp=%b want FF 7F 1", n, an, seg, dp);
      end
    end
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_scan();
    logic [7:0] an_tab  [12] = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD,
                                 8'hFF, 8'hFB, 8'hFB, 8'hFB};
    logic [6:0] seg_tab [12] = '{7'h7F, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h78, 7'h78, 7'h78,
                                 7'h7F, 7'h02, 7'h02, 7'h02};
    logic       dp_tab  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 12; n++) begin
      tick();
      n_checks++;
      if (an !== an_tab[n] || seg !== seg_tab[n] || dp !== dp_tab[n]) begin
        n_fail++;
        $display("FAIL scan_first k=%0d an=%h seg=%h dp=%b want %h %h %b",
                 k, an, seg, dp, an_tab[n], seg_tab[n], dp_tab[n]);
      end
    end
    while (k < 31) begin
      tick();
      model(k);
      n_checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        n_fail++;
        $display("FAIL scan k=%0d an=%h seg=%h dp=%b want %h %h %b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] an_tab  [3] = '{8'h7F, 8'hFF, 8'hFE};
    logic [6:0] seg_tab [3] = '{7'h79, 7'h7F, 7'h00};
    for (int n = 0; n < 3; n++) begin
      tick();
      n_checks++;
      if (an !== an_tab[n] || seg !== seg_tab[n]) begin
        n_fail++;
        $display("FAIL wrap k=%0d an=%h seg=%h want %h %h", k, an, seg, an_tab[n], seg_tab[n]);
      end
    end
  endtask

  task automatic test_invalid_bcd();
    time_i = 36'h12C456789;
    for (int n = 0; n < 32; n++) begin
      tick();
      model(k);
      n_checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        n_fail++;
        $display("FAIL invalid_bcd k=%0d an=%h seg=%h dp=%b want %h %h %b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (an === 8'hDF) begin
        n_checks++;
        if (seg !== 7'h7F) begin
          n_fail++;
          $display("FAIL invalid_bcd_blank k=%0d seg=%h want 7F", k, seg);
        end
      end
    end
    time_i = 36'h123456789;
  endtask

  task automatic test_edit_blink();
    edit = 1'b1; curr_digit = 3'd2;
    while (k < 140) begin
      tick();
      model(k);
      n_checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        n_fail++;
        $display("FAIL edit_blink k=%0d an=%h seg=%h dp=%b want %h %h %b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (an === 8'hDF) begin
        n_checks++;
        if (seg !== ((((k - 1) / BLINK_HALF) % 2 == 1) ? 7'h7F : 7'h30)) begin
          n_fail++;
          $display("FAIL edit_m2 k=%0d seg=%h", k, seg);
        end
      end
    end
    curr_digit = 3'd6;
    while (k < 260) begin
      tick();
      model(k);
      n_checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        n_fail++;
        $display("FAIL edit_none k=%0d an=%h seg=%h dp=%b want %h %h %b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_done_flash();
    done = 1'b1; edit = 1'b1; curr_digit = 3'd2;
    while (k < 400) begin
      tick();
      model(k);
      n_checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        n_fail++;
        $display("FAIL done_flash k=%0d an=%h seg=%h dp=%b want %h %h %b", k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    // Stop once the state is idx = 5, cnt = 2, ph = 0 (k edges taken so far).
    while (!((k % 32) == 22 && ((k / BLINK_HALF) % 2) == 1) && guard < 300) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 300) begin
      n_fail++;
      $display("FAIL reset_mid_seek k=%0d", k);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid an=%h seg=%h dp=%b want FF 7F 1", an, seg, dp);
    end
    rst_n = 1'b1;
    k = 0;
    tick();
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_guard an=%h seg=%h dp=%b want FF 7F 1", an, seg, dp);
    end
    // done is still high: the digit is visible only if ph restarted at 1.
    tick();
    n_checks++;
    if (an !== 8'hFE || seg !== 7'h00 || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_first an=%h seg=%h dp=%b want FE 00 1", an, seg, dp);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_wrap();
    test_invalid_bcd();
    test_edit_blink();
    test_done_flash();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
